// File: rtl/lc3_decode_pkg.sv
// rtl/lc3_decode_pkg.sv - LC-3 decode stage opcodes, control encodings and field positions
package lc3_decode_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RSV  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } op_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    localparam logic [1:0] PCSEL1_NONE = 2'b00;
    localparam logic [1:0] PCSEL1_OFF9 = 2'b01;
    localparam logic [1:0] PCSEL1_OFF6 = 2'b10;
    localparam logic [1:0] PCSEL1_ZERO = 2'b11;

    localparam logic [1:0] W_ALU = 2'b00;
    localparam logic [1:0] W_MEM = 2'b01;
    localparam logic [1:0] W_PC  = 2'b10;

    localparam int E_ALU_LSB    = 4;
    localparam int E_PCSEL1_LSB = 2;
    localparam int E_PCSEL2_BIT = 1;
    localparam int E_OP2_BIT    = 0;

    // Opcodes this stage does not decode into any control
    function automatic logic is_unsupported(input op_t op);
        return (op == OP_JSR) || (op == OP_RTI) || (op == OP_RSV) || (op == OP_TRAP);
    endfunction

endpackage

// File: rtl/lc3_decode_if.sv
// rtl/lc3_decode_if.sv - fetch-to-decode inputs and decode-to-execute outputs
interface lc3_decode_if;
    logic        enable_decode_i;
    logic [15:0] dout_i;
    logic [15:0] npc_in_i;
    logic [15:0] ir_o;
    logic [15:0] npc_out_o;
    logic [5:0]  e_control_o;
    logic [1:0]  w_control_o;
    logic        mem_control_o;
    logic        valid_o;

    modport master (
        output enable_decode_i, dout_i, npc_in_i,
        input  ir_o, npc_out_o, e_control_o, w_control_o, mem_control_o, valid_o
    );

    modport slave (
        input  enable_decode_i, dout_i, npc_in_i,
        output ir_o, npc_out_o, e_control_o, w_control_o, mem_control_o, valid_o
    );
endinterface

// File: rtl/lc3_decode_ctrl.sv
// rtl/lc3_decode_ctrl.sv - combinational opcode to execute/writeback/memory control mapping
module lc3_decode_ctrl
    import lc3_decode_pkg::*;
(
    input  op_t        op,
    input  logic       ir5,
    output logic [5:0] e_control,
    output logic [1:0] w_control,
    output logic       mem_control
);

    logic [1:0] alu;
    logic [1:0] pcsel1;
    logic       pcsel2;
    logic       op2sel;

    always_comb begin
        alu         = ALU_ADD;
        pcsel1      = PCSEL1_NONE;
        pcsel2      = 1'b0;
        op2sel      = 1'b0;
        w_control   = W_ALU;
        mem_control = 1'b0;
        case (op)
            OP_ADD: begin alu = ALU_ADD; op2sel = ~ir5; end
            OP_AND: begin alu = ALU_AND; op2sel = ~ir5; end
            OP_NOT: begin alu = ALU_NOT; op2sel = 1'b1; end
            OP_BR:  begin pcsel1 = PCSEL1_OFF9; pcsel2 = 1'b1; end
            OP_JMP: begin pcsel1 = PCSEL1_ZERO; pcsel2 = 1'b0; end
            OP_LD:  begin pcsel1 = PCSEL1_OFF9; pcsel2 = 1'b1; w_control = W_MEM; end
            OP_ST:  begin pcsel1 = PCSEL1_OFF9; pcsel2 = 1'b1; end
            OP_LDI: begin pcsel1 = PCSEL1_OFF9; pcsel2 = 1'b1; w_control = W_MEM; mem_control = 1'b1; end
            OP_STI: begin pcsel1 = PCSEL1_OFF9; pcsel2 = 1'b1; mem_control = 1'b1; end
            OP_LDR: begin pcsel1 = PCSEL1_OFF6; w_control = W_MEM; end
            OP_STR: begin pcsel1 = PCSEL1_OFF6; end
            OP_LEA: begin pcsel1 = PCSEL1_OFF9; pcsel2 = 1'b1; w_control = W_PC; end
            default: ;
        endcase
    end

    always_comb begin
        e_control                                   = '0;
        e_control[E_ALU_LSB+1:E_ALU_LSB]           = alu;
        e_control[E_PCSEL1_LSB+1:E_PCSEL1_LSB]     = pcsel1;
        e_control[E_PCSEL2_BIT]                     = pcsel2;
        e_control[E_OP2_BIT]                        = op2sel;
    end

endmodule

// File: rtl/lc3_decode_stage.sv
// rtl/lc3_decode_stage.sv - registered LC-3 decode stage; LC3_DECODE_ILLEGAL_EN adds illegal-opcode flag and counter
module lc3_decode_stage
    import lc3_decode_pkg::*;
(
    input  logic          clock_i,
    input  logic          reset_i,
`ifdef LC3_DECODE_ILLEGAL_EN
    output logic          illegal_o,
    output logic [7:0]    illegal_cnt_o,
`endif
    lc3_decode_if.slave   dec
);

    op_t        op;
    logic [5:0] e_dec;
    logic [1:0] w_dec;
    logic       mem_dec;

    assign op = op_t'(dec.dout_i[15:12]);

    lc3_decode_ctrl u_ctrl (
        .op          (op),
        .ir5         (dec.dout_i[5]),
        .e_control   (e_dec),
        .w_control   (w_dec),
        .mem_control (mem_dec)
    );

    logic [15:0] ir_q, ir_d;
    logic [15:0] npc_q, npc_d;
    logic [5:0]  e_q, e_d;
    logic [1:0]  w_q, w_d;
    logic        mem_q, mem_d;
    logic        valid_q, valid_d;

    // Disabled cycles hold every captured field; only valid drops
    always_comb begin
        ir_d    = ir_q;
        npc_d   = npc_q;
        e_d     = e_q;
        w_d     = w_q;
        mem_d   = mem_q;
        valid_d = dec.enable_decode_i;
        if (dec.enable_decode_i) begin
            ir_d  = dec.dout_i;
            npc_d = dec.npc_in_i;
            e_d   = e_dec;
            w_d   = w_dec;
            mem_d = mem_dec;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ir_q    <= '0;
            npc_q   <= '0;
            e_q     <= '0;
            w_q     <= '0;
            mem_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            npc_q   <= npc_d;
            e_q     <= e_d;
            w_q     <= w_d;
            mem_q   <= mem_d;
            valid_q <= valid_d;
        end
    end

    assign dec.ir_o          = ir_q;
    assign dec.npc_out_o     = npc_q;
    assign dec.e_control_o   = e_q;
    assign dec.w_control_o   = w_q;
    assign dec.mem_control_o = mem_q;
    assign dec.valid_o       = valid_q;

`ifdef LC3_DECODE_ILLEGAL_EN
    logic       illegal_q, illegal_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        illegal_d = dec.enable_decode_i && is_unsupported(op);
        cnt_d     = cnt_q;
        if (illegal_d && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign illegal_o     = illegal_q;
    assign illegal_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_lc3_decode_stage.sv
// tb/tb_lc3_decode_stage.sv - directed self-checking bench for lc3_decode_stage
module tb_lc3_decode_stage;

    logic clock_i = 1'b0;
    logic reset_i = 1'b1;
`ifdef LC3_DECODE_ILLEGAL_EN
    logic       illegal_o;
    logic [7:0] illegal_cnt_o;
`endif

    lc3_decode_if dif();

    lc3_decode_stage dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
`ifdef LC3_DECODE_ILLEGAL_EN
        .illegal_o     (illegal_o),
        .illegal_cnt_o (illegal_cnt_o),
`endif
        .dec           (dif)
    );

    always #5 clock_i = ~clock_i;

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Apply inputs, take one rising edge, settle 1ns after it
    task automatic cycle(input logic en, input logic [15:0] dout, input logic [15:0] npc);
        dif.enable_decode_i = en;
        dif.dout_i          = dout;
        dif.npc_in_i        = npc;
        @(posedge clock_i);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [15:0] ir, input logic [15:0] npc,
                           input logic [5:0] e, input logic [1:0] w, input logic mem,
                           input logic v);
        chk({tag, ".ir"},  dif.ir_o, ir);
        chk({tag, ".npc"}, dif.npc_out_o, npc);
        chk({tag, ".e"},   {10'd0, dif.e_control_o}, {10'd0, e});
        chk({tag, ".w"},   {14'd0, dif.w_control_o}, {14'd0, w});
        chk({tag, ".mem"}, {15'd0, dif.mem_control_o}, {15'd0, mem});
        chk({tag, ".v"},   {15'd0, dif.valid_o}, {15'd0, v});
    endtask

    typedef struct {
        logic [15:0] ir;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        mem;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{16'h967F, 6'b100001, 2'b00, 1'b0};
        tbl[1] = '{16'h0402, 6'b000110, 2'b00, 1'b0};
        tbl[2] = '{16'hC1C0, 6'b001100, 2'b00, 1'b0};
        tbl[3] = '{16'hB201, 6'b000110, 2'b00, 1'b1};
        tbl[4] = '{16'h2404, 6'b000110, 2'b01, 1'b0};
        tbl[5] = '{16'h7283, 6'b001000, 2'b00, 1'b0};
        tbl[6] = '{16'hF025, 6'b000000, 2'b00, 1'b0};
        tbl[7] = '{16'h12A3, 6'b000000, 2'b00, 1'b0};

        dif.enable_decode_i = 1'b0;
        dif.dout_i          = 16'h0000;
        dif.npc_in_i        = 16'h0000;
        repeat (2) @(posedge clock_i);
        #1;
        chk_all("rst", 16'h0000, 16'h0000, 6'b0, 2'b00, 1'b0, 1'b0);
`ifdef LC3_DECODE_ILLEGAL_EN
        chk("rst.ill", {15'd0, illegal_o}, 16'd0);
        chk("rst.cnt", {8'd0, illegal_cnt_o}, 16'd0);
`endif
        @(negedge clock_i);
        reset_i = 1'b0;

        cycle(1'b1, 16'h1283, 16'h3001);
        chk_all("add", 16'h1283, 16'h3001, 6'b000001, 2'b00, 1'b0, 1'b1);

        cycle(1'b1, 16'h52A5, 16'h3002);
        chk_all("and", 16'h52A5, 16'h3002, 6'b010000, 2'b00, 1'b0, 1'b1);
        cycle(1'b1, 16'h6283, 16'h3003);
        chk_all("ldr", 16'h6283, 16'h3003, 6'b001000, 2'b01, 1'b0, 1'b1);

        cycle(1'b1, 16'hA201, 16'h3004);
        chk_all("ldi", 16'hA201, 16'h3004, 6'b000110, 2'b01, 1'b1, 1'b1);
        cycle(1'b1, 16'hE005, 16'h3005);
        chk_all("lea", 16'hE005, 16'h3005, 6'b000110, 2'b10, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, tbl[i].ir, 16'h4000 + 16'(i));
            chk_all($sformatf("tbl%0d", i), tbl[i].ir, 16'h4000 + 16'(i),
                    tbl[i].e, tbl[i].w, tbl[i].mem, 1'b1);
        end

        cycle(1'b1, 16'h1283, 16'h3010);
        chk_all("pre_stall", 16'h1283, 16'h3010, 6'b000001, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 16'hFFFF, 16'hFFFF);
            chk_all($sformatf("stall%0d", i), 16'h1283, 16'h3010, 6'b000001, 2'b00, 1'b0, 1'b0);
        end

        cycle(1'b1, 16'hA201, 16'h3020);
        #2;
        reset_i = 1'b1;
        #1;
        chk_all("async_rst", 16'h0000, 16'h0000, 6'b0, 2'b00, 1'b0, 1'b0);
        #2;
        reset_i = 1'b0;
        cycle(1'b1, 16'h5020, 16'h3030);
        chk_all("post_rst", 16'h5020, 16'h3030, 6'b010000, 2'b00, 1'b0, 1'b1);

`ifdef LC3_DECODE_ILLEGAL_EN
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'hD000, 16'h5000);
            chk($sformatf("ill%0d.pulse", i), {15'd0, illegal_o}, 16'd1);
            chk($sformatf("ill%0d.cnt", i), {8'd0, illegal_cnt_o}, 16'(i + 1));
            chk($sformatf("ill%0d.e", i), {10'd0, dif.e_control_o}, 16'd0);
            cycle(1'b1, 16'h1283, 16'h5001);
            chk($sformatf("ill%0d.gap", i), {15'd0, illegal_o}, 16'd0);
        end
        cycle(1'b0, 16'hD000, 16'h5000);
        chk("ill.dis", {15'd0, illegal_o}, 16'd0);
        chk("ill.dis_cnt", {8'd0, illegal_cnt_o}, 16'd3);
        for (int i = 3; i < 260; i++) begin
            cycle(1'b1, 16'hF025, 16'h5000);
        end
        chk("ill.sat", {8'd0, illegal_cnt_o}, 16'd255);
        chk("ill.sat_pulse", {15'd0, illegal_o}, 16'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/lc3_decode_stage.md
# lc3_decode_stage

Registered LC-3 decode stage that sits directly downstream of the fetch stage and is driven by the `decode_in` interface. When `enable_decode_i` is high, the stage captures the fetched instruction (`dout_i`) and the next-PC (`npc_in_i`). One cycle later it presents the instruction register, the forwarded NPC, and the execute/writeback/memory control words to the execute stage. When enable is low, all outputs hold, which implements a fetch/decode stall.

## Interface
- Parameters: none. Widths are fixed by the LC-3 ISA.
- `clock_i` in 1: stage clock.
- `reset_i` in 1: reset, asynchronous, active-high.
- `enable_decode_i` in 1: capture strobe from the controller.
- `dout_i` in 16: instruction word from instruction memory.
- `npc_in_i` in 16: PC+1 from fetch.
- `ir_o` out 16: registered instruction.
- `npc_out_o` out 16: registered NPC.
- `e_control_o` out 6: execute control word, `{alu_control[1:0], pcselect1[1:0], pcselect2, op2select}`.
- `w_control_o` out 2: writeback select. 00 = ALU, 01 = memory, 10 = PC-relative address.
- `mem_control_o` out 1: 1 = indirect access (LDI/STI).
- `valid_o` out 1: registered copy of `enable_decode_i`.

## Operation
- All outputs reset to 0.
- On each `posedge clock_i` with `enable_decode_i` = 1:
  - `ir_o` ← `dout_i`, `npc_out_o` ← `npc_in_i`.
  - Control words ← decode of `dout_i[15:12]`.
- With `enable_decode_i` = 0, `ir_o`, `npc_out_o` and all control words hold their values; `valid_o` ← 0.
- Decode table. Any field not listed is 0.
  - ADD 0001: alu 00; op2select = ~IR[5] (1 = register operand, 0 = imm5); w 00.
  - AND 0101: alu 01; op2select = ~IR[5]; w 00.
  - NOT 1001: alu 10; op2select 1; w 00.
  - BR 0000: pcselect1 01 (offset9); pcselect2 1 (NPC).
  - JMP 1100: pcselect1 11 (zero); pcselect2 0 (base register).
  - LD 0010, ST 0011, LDI 1010, STI 1011: pcselect1 01; pcselect2 1.
    - LD/LDI: w 01.
    - LDI/STI: mem 1.
  - LDR 0110, STR 0111: pcselect1 10 (offset6); pcselect2 0.
    - LDR: w 01.
  - LEA 1110: pcselect1 01; pcselect2 1; w 10.
  - JSR 0100, RTI 1000, reserved 1101, TRAP 1111: all controls 0; IR and NPC still captured.
- Reset asserted mid-operation clears all outputs immediately, regardless of clock or enable.
- Enable re-asserted on the first edge after reset deassertion captures normally.

## Timing
- Latency is 1 cycle from the `enable_decode_i` sampling edge to valid outputs.
- Throughput is one instruction per cycle. Back-to-back enables produce a new decode every cycle.
- No combinational path from inputs to outputs. The decode logic feeds the output registers only.
- `valid_o` follows `enable_decode_i` delayed by exactly one cycle.

## Configuration
- Macro: `LC3_DECODE_ILLEGAL_EN`.
- When defined, the block adds two outputs:
  - `illegal_o` (1 bit): registered, high for one cycle per captured JSR/RTI/1101/TRAP opcode.
  - `illegal_cnt_o` (8 bits): count of such captures. Reset 0, saturates at 255, increments only on enabled captures.
- When not defined, neither port nor the counter exists. Unsupported opcodes decode to all-zero controls, silently.

## Structure
- Package `lc3_decode_pkg` holds:
  - the `op_t` 4-bit opcode enum;
  - localparams for ALU codes, pcselect1 codes and the w_control encodings;
  - the `e_control` bit-position constants.
- One sub-module, `lc3_decode_ctrl`: purely combinational mapping from opcode and IR[5] to `{e_control, w_control, mem_control}`. It is instantiated once and feeds the registers in `lc3_decode_stage`.

## Test plan
- Reset, then `dout_i` = 0x1283 (ADD R1,R2,R3), `npc_in_i` = 0x3001, enable for 1 cycle. Required next cycle: `ir_o` = 0x1283, `npc_out_o` = 0x3001, `e_control_o` = 6'b000001, `w_control_o` = 00, `mem_control_o` = 0, `valid_o` = 1.
- Back-to-back captures:
  - `dout_i` = 0x52A5 (AND imm) → `e_control_o` = 6'b010000.
  - then 0x6283 (LDR) → `e_control_o` = 6'b001000, `w_control_o` = 01.
  - Each appears exactly one cycle after its capture edge.
- Capture 0xA201 (LDI), then 0xE005 (LEA):
  - LDI → `e_control_o` = 6'b000110, `w_control_o` = 01, `mem_control_o` = 1.
  - LEA → `e_control_o` = 6'b000110, `w_control_o` = 10, `mem_control_o` = 0.
- Capture 0x1283, then drop enable for 3 cycles while changing `dout_i` to 0xFFFF. Required: outputs hold at 0x1283 decode; `valid_o` = 0 during the stall.
- With enable high, assert `reset_i` between clock edges. Required: all outputs read 0 before the next edge; capture resumes on the first edge after release.
- With `LC3_DECODE_ILLEGAL_EN`, capture 0xD000 three times. Required: three `illegal_o` pulses, `illegal_cnt_o` = 3, all controls 0. After 260 captures, `illegal_cnt_o` = 255.
